// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: Moore FSM with a memory wait-state handshake,
// a bounded wait timeout and a sticky FAULT state.
module multicycle_controller #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd15
    } state_t;

    // Last wait count tolerated before the timeout fires; unused when WAIT_LIMIT is 0.
    localparam logic [CNT_W-1:0] LIM_M1 = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_mem_state;
    logic             w_timeout;
    logic             w_funct_ok;
    logic [2:0]       w_rfn;
    logic             w_pcwrite;
    logic             w_branch;
    logic             w_irwrite;
    logic             w_regwrite;
    logic             w_memwrite;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_timeout   = (WAIT_LIMIT > 0) && w_mem_state && !mem_ready && (r_wait_cnt == LIM_M1);

    // R-type funct decode; unknown funct codes are flagged so EXECUTE can fault.
    always_comb begin
        w_funct_ok = 1'b1;
        w_rfn      = 3'b010;
        case (funct)
            6'b100000: w_rfn = 3'b010;
            6'b100010: w_rfn = 3'b110;
            6'b100100: w_rfn = 3'b000;
            6'b100101: w_rfn = 3'b001;
            6'b101010: w_rfn = 3'b111;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    // Next-state logic; a memory wait timeout overrides every other transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    6'b100011, 6'b101011: w_next = S_MEMADR;
                    6'b000000:            w_next = S_EXECUTE;
                    6'b000100:            w_next = S_BRANCH;
                    6'b001000:            w_next = S_ADDIEXEC;
                    6'b000010:            w_next = S_JUMP;
                    default:              w_next = S_FAULT;
                endcase
            end
            S_MEMADR:   w_next = (op == 6'b100011) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXECUTE:  w_next = w_funct_ok ? S_ALUWB : S_FAULT;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_ADDIEXEC: w_next = S_ADDIWB;
            S_ADDIWB:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            default:    w_next = S_FAULT;
        endcase
        if (w_timeout) w_next = S_FAULT;
    end

    // Moore output decode; enables are gated by reset so nothing writes while it is held.
    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b010;
        case (r_state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE:   alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMREAD:  iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                iord       = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_rfn;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                w_branch   = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:   w_regwrite = 1'b1;
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen     = reset & (w_pcwrite | (w_branch & zero));
    assign irwrite  = reset & w_irwrite;
    assign regwrite = reset & w_regwrite;
    assign memwrite = reset & w_memwrite;
    assign state    = r_state;
    assign fault    = (r_state == S_FAULT);

    // State register and wait counter; the counter only runs while stalled in a memory state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_mem_state && !mem_ready && (w_next == r_state))
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: the driver pushes hand-computed expected outputs per cycle,
// a monitor on the falling edge pops and compares them.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       fault;

    multicycle_controller #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
        .memwrite(memwrite), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    // Vector layout: fault pcen irwrite regwrite memwrite iord memtoreg regdst alusrca _ alusrcb _ pcsrc _ alucontrol
    localparam logic [15:0] FWAIT  = 16'b0_0_0_0_0_0_0_0_0_01_00_010;
    localparam logic [15:0] FRDY   = 16'b0_1_1_0_0_0_0_0_0_01_00_010;
    localparam logic [15:0] DEC    = 16'b0_0_0_0_0_0_0_0_0_11_00_010;
    localparam logic [15:0] MADR   = 16'b0_0_0_0_0_0_0_0_1_10_00_010;
    localparam logic [15:0] MRD    = 16'b0_0_0_0_0_1_0_0_0_00_00_010;
    localparam logic [15:0] MWB    = 16'b0_0_0_1_0_0_1_0_0_00_00_010;
    localparam logic [15:0] MWR    = 16'b0_0_0_0_1_1_0_0_0_00_00_010;
    localparam logic [15:0] EXADD  = 16'b0_0_0_0_0_0_0_0_1_00_00_010;
    localparam logic [15:0] EXSUB  = 16'b0_0_0_0_0_0_0_0_1_00_00_110;
    localparam logic [15:0] EXSLT  = 16'b0_0_0_0_0_0_0_0_1_00_00_111;
    localparam logic [15:0] ALUWB  = 16'b0_0_0_1_0_0_0_1_0_00_00_010;
    localparam logic [15:0] BR1    = 16'b0_1_0_0_0_0_0_0_1_00_01_110;
    localparam logic [15:0] BR0    = 16'b0_0_0_0_0_0_0_0_1_00_01_110;
    localparam logic [15:0] ADDIE  = 16'b0_0_0_0_0_0_0_0_1_10_00_010;
    localparam logic [15:0] ADDIW  = 16'b0_0_0_1_0_0_0_0_0_00_00_010;
    localparam logic [15:0] JMP    = 16'b0_1_0_0_0_0_0_0_0_00_10_010;
    localparam logic [15:0] FLT    = 16'b1_0_0_0_0_0_0_0_0_00_00_010;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] v;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    wire [15:0] act_v = {fault, pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
                         alusrca, alusrcb, pcsrc, alucontrol};

    // One cycle of stimulus: drive inputs just after the rising edge, queue the expected outputs.
    task automatic cyc(input logic rst, input logic mr, input logic z, input logic [5:0] o,
                       input logic [5:0] f, input logic [3:0] est, input logic [15:0] ev,
                       input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = mr;
        zero      = z;
        op        = o;
        funct     = f;
        e.st = est;
        e.v  = ev;
        e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: compare every queued expectation against the DUT on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (state !== e.st || act_v !== e.v) begin
                bad++;
                $display("FAIL %s: got state=%0d vec=%b, want state=%0d vec=%b",
                         e.nm, state, act_v, e.st, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = '0; funct = '0;
        // reset held: FETCH selects, enables forced off although mem_ready=1
        cyc(0, 1, 0, RT, 0, 0, FWAIT, "reset");
        cyc(0, 1, 0, RT, 0, 0, FWAIT, "reset_hold");
        // lw, no waits: 0,1,2,3,4,0
        cyc(1, 1, 0, LW, 0, 0, FRDY, "lw_fetch");
        cyc(1, 1, 0, LW, 0, 1, DEC,  "lw_decode");
        cyc(1, 1, 0, LW, 0, 2, MADR, "lw_memadr");
        cyc(1, 1, 0, LW, 0, 3, MRD,  "lw_memread");
        cyc(1, 1, 0, LW, 0, 4, MWB,  "lw_memwb");
        // FETCH stall for three cycles
        cyc(1, 0, 0, BEQ, 0, 0, FWAIT, "fetch_wait1");
        cyc(1, 0, 0, BEQ, 0, 0, FWAIT, "fetch_wait2");
        cyc(1, 0, 0, BEQ, 0, 0, FWAIT, "fetch_wait3");
        cyc(1, 1, 0, BEQ, 0, 0, FRDY,  "fetch_go");
        // beq taken then not taken
        cyc(1, 1, 1, BEQ, 0, 1, DEC,  "beq_decode");
        cyc(1, 1, 1, BEQ, 0, 8, BR1,  "beq_taken");
        cyc(1, 1, 0, BEQ, 0, 0, FRDY, "beq2_fetch");
        cyc(1, 1, 0, BEQ, 0, 1, DEC,  "beq2_decode");
        cyc(1, 1, 0, BEQ, 0, 8, BR0,  "beq_not_taken");
        // R-type slt, sub, add
        cyc(1, 1, 0, RT, 6'b101010, 0, FRDY,  "slt_fetch");
        cyc(1, 1, 0, RT, 6'b101010, 1, DEC,   "slt_decode");
        cyc(1, 1, 0, RT, 6'b101010, 6, EXSLT, "slt_execute");
        cyc(1, 1, 0, RT, 6'b101010, 7, ALUWB, "slt_aluwb");
        cyc(1, 1, 0, RT, 6'b100010, 0, FRDY,  "sub_fetch");
        cyc(1, 1, 0, RT, 6'b100010, 1, DEC,   "sub_decode");
        cyc(1, 1, 0, RT, 6'b100010, 6, EXSUB, "sub_execute");
        cyc(1, 1, 0, RT, 6'b100000, 7, ALUWB, "sub_aluwb");
        // addi
        cyc(1, 1, 0, ADDI, 0, 0, FRDY,  "addi_fetch");
        cyc(1, 1, 0, ADDI, 0, 1, DEC,   "addi_decode");
        cyc(1, 1, 0, ADDI, 0, 9, ADDIE, "addi_exec");
        cyc(1, 1, 0, ADDI, 0, 10, ADDIW, "addi_wb");
        // j
        cyc(1, 1, 0, J, 0, 0, FRDY, "j_fetch");
        cyc(1, 1, 0, J, 0, 1, DEC,  "j_decode");
        cyc(1, 1, 0, J, 0, 11, JMP, "j_jump");
        // lw with two MEMREAD wait states
        cyc(1, 1, 0, LW, 0, 0, FRDY, "lww_fetch");
        cyc(1, 1, 0, LW, 0, 1, DEC,  "lww_decode");
        cyc(1, 1, 0, LW, 0, 2, MADR, "lww_memadr");
        cyc(1, 0, 0, LW, 0, 3, MRD,  "lww_wait1");
        cyc(1, 0, 0, LW, 0, 3, MRD,  "lww_wait2");
        cyc(1, 1, 0, LW, 0, 3, MRD,  "lww_ready");
        cyc(1, 1, 0, LW, 0, 4, MWB,  "lww_memwb");
        // sw, no waits
        cyc(1, 1, 0, SW, 0, 0, FRDY, "sw_fetch");
        cyc(1, 1, 0, SW, 0, 1, DEC,  "sw_decode");
        cyc(1, 1, 0, SW, 0, 2, MADR, "sw_memadr");
        cyc(1, 1, 0, SW, 0, 5, MWR,  "sw_memwrite");
        // unknown funct faults from EXECUTE
        cyc(1, 1, 0, RT, 6'b000000, 0, FRDY,  "badfn_fetch");
        cyc(1, 1, 0, RT, 6'b000000, 1, DEC,   "badfn_decode");
        cyc(1, 1, 0, RT, 6'b000000, 6, EXADD, "badfn_execute");
        cyc(1, 1, 1, RT, 6'b000000, 15, FLT,  "badfn_fault");
        cyc(0, 1, 0, RT, 0, 0, FWAIT, "rst_pulse1");
        // unknown opcode: sticky FAULT for 20 cycles with toggling inputs
        cyc(1, 1, 0, BAD, 0, 0, FRDY, "badop_fetch");
        cyc(1, 1, 1, BAD, 0, 1, DEC,  "badop_decode");
        for (int i = 0; i < 20; i++)
            cyc(1, i[0], 1, (i[1] ? J : BAD), 0, 15, FLT, "badop_fault_hold");
        cyc(0, 1, 0, SW, 0, 0, FWAIT, "rst_pulse2");
        // MEMWRITE stalls 15 cycles -> FAULT on the 16th
        cyc(1, 1, 0, SW, 0, 0, FRDY, "swto_fetch");
        cyc(1, 1, 0, SW, 0, 1, DEC,  "swto_decode");
        cyc(1, 1, 0, SW, 0, 2, MADR, "swto_memadr");
        for (int i = 0; i < 15; i++)
            cyc(1, 0, 0, SW, 0, 5, MWR, "swto_wait");
        cyc(1, 0, 0, SW, 0, 15, FLT, "swto_fault");
        cyc(0, 1, 0, SW, 0, 0, FWAIT, "rst_pulse3");
        // 14 stalls then mem_ready in the limit cycle: normal advance wins
        cyc(1, 1, 0, SW, 0, 0, FRDY, "swlim_fetch");
        cyc(1, 1, 0, SW, 0, 1, DEC,  "swlim_decode");
        cyc(1, 1, 0, SW, 0, 2, MADR, "swlim_memadr");
        for (int i = 0; i < 14; i++)
            cyc(1, 0, 0, SW, 0, 5, MWR, "swlim_wait");
        cyc(1, 1, 0, SW, 0, 5, MWR,  "swlim_ready");
        cyc(1, 1, 0, SW, 0, 0, FRDY, "swlim_back_fetch");
        // reset asserted mid-MEMWRITE drops memwrite immediately
        cyc(1, 1, 0, SW, 0, 1, DEC,   "swrst_decode");
        cyc(1, 1, 0, SW, 0, 2, MADR,  "swrst_memadr");
        cyc(1, 0, 0, SW, 0, 5, MWR,   "swrst_wait1");
        cyc(1, 0, 0, SW, 0, 5, MWR,   "swrst_wait2");
        cyc(0, 1, 0, SW, 0, 0, FWAIT, "swrst_reset_low");
        cyc(1, 1, 0, SW, 0, 0, FRDY,  "swrst_after");
        cyc(1, 1, 0, SW, 0, 1, DEC,   "swrst_decode2");

        // let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() > 0)
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
